// File: rtl/if_prefetch.sv
// if_prefetch: decoupled instruction fetch with a req/ack memory port and a prefetch queue toward IF_ID.
// Branches flush the queue; a request already in flight is completed and its data dropped.
module if_prefetch #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  is_branch,
    input  logic [ADDR_WIDTH-1:0] branch_address,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [ADDR_WIDTH-1:0] out_pc_plus4,
    output logic [DATA_WIDTH-1:0] out_inst
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(QUEUE_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] fetch_pc, stale_pc;
    logic [CW-1:0]         count, next_count;
    logic [PW-1:0]         head, tail;
    logic [ADDR_WIDTH-1:0] pc_q [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0] inst_q [QUEUE_DEPTH];
    logic                  push, pop;

    assign push       = state == REQ && mem_ack && !is_branch;
    assign pop        = out_valid && out_ready && !is_branch;
    assign next_count = count + CW'(push) - CW'(pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // A request is only issued or kept while a queue slot is free, so an ack can never overflow.
    always_comb begin
        state_nxt = state == IDLE ? ((is_branch || next_count < FULL) ? REQ : IDLE)
                  : state == REQ  ? (is_branch ? (mem_ack ? REQ : DISCARD)
                                               : ((mem_ack && next_count >= FULL) ? IDLE : REQ))
                  : (mem_ack ? REQ : DISCARD);
    end

    always_comb begin
        mem_req  = state != IDLE;
        mem_addr = state == DISCARD ? stale_pc : fetch_pc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            stale_pc <= RESET_PC;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
        end else if (is_branch) begin
            count    <= '0;
            head     <= tail;
            fetch_pc <= branch_address & ~ADDR_WIDTH'(3);
            // The in-flight address must stay on the bus until its ack, even though fetch_pc moves on.
            if (state == REQ && !mem_ack)
                stale_pc <= fetch_pc;
        end else begin
            count <= next_count;
            head  <= head + PW'(pop);
            tail  <= tail + PW'(push);
            if (push)
                fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[tail]   <= fetch_pc;
            inst_q[tail] <= mem_rdata;
        end
    end

    assign out_valid    = count != '0;
    assign out_pc       = pc_q[head];
    assign out_inst     = inst_q[head];
    assign out_pc_plus4 = out_pc + ADDR_WIDTH'(4);
endmodule
